// File: rtl/adq_datapath_if.sv
// Bus between the acquisition FSM/host side and the acquisition datapath.
// The master drives control, ADC and read-address inputs. The slave returns status, buffer and statistics.
interface adq_datapath_if #(
  parameter int DW = 12,
  parameter int AW = 4
);
  logic [6:0]       ctrl;
  logic             adc_eoc_raw;
  logic [DW-1:0]    adc_data;
  logic             adc_soc;
  logic             eoc;
  logic             fac;
  logic             busy;
  logic             done;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [DW-1:0]    rd_data;
  logic [DW-1:0]    max_val;
  logic [DW-1:0]    min_val;
  logic [DW+AW-1:0] sum;

  modport master (
    output ctrl, adc_eoc_raw, adc_data, rd_addr,
    input  adc_soc, eoc, fac, busy, done, wr_addr, rd_data, max_val, min_val, sum
  );

  modport slave (
    input  ctrl, adc_eoc_raw, adc_data, rd_addr,
    output adc_soc, eoc, fac, busy, done, wr_addr, rd_data, max_val, min_val, sum
  );
endinterface

// File: rtl/adq_datapath.sv
// Acquisition datapath: decodes the FSM control word, synchronises ADC EOC, buffers samples and keeps statistics.
// Latency: control effects on the next clk, eoc 3 clk after the raw rise, rd_data 1 clk. No backpressure; the FSM paces everything.
module adq_datapath #(
  parameter int DW    = 12,
  parameter int AW    = 4,
  parameter int NSAMP = 16
) (
  input  logic          clk,
  input  logic          rst,
  adq_datapath_if.slave bus
);
  localparam logic [AW-1:0] LAST = AW'(NSAMP - 1);

  logic clr, inc, latch, wr_en;
  assign clr   = bus.ctrl[1];
  assign inc   = bus.ctrl[2];
  assign latch = bus.ctrl[4];
  assign wr_en = bus.ctrl[5];

  assign bus.busy    = bus.ctrl[0];
  assign bus.adc_soc = bus.ctrl[3];
  assign bus.done    = bus.ctrl[6];

  logic [AW-1:0]    wr_addr_q;
  logic [DW-1:0]    max_q;
  logic [DW-1:0]    min_q;
  logic [DW+AW-1:0] sum_q;
  logic [DW-1:0]    rd_q;
  logic [2:0]       sync_q;
  logic             eoc_q;
  logic [DW-1:0]    mem [2**AW];

  // sync_q[1] is the synchronised level; sync_q[2] is its previous value for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      eoc_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], bus.adc_eoc_raw};
      eoc_q  <= sync_q[1] & ~sync_q[2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr_q <= '0;
      max_q     <= '0;
      min_q     <= '1;
      sum_q     <= '0;
    end else if (clr) begin
      wr_addr_q <= '0;
      max_q     <= '0;
      min_q     <= '1;
      sum_q     <= '0;
    end else begin
      if (latch) begin
        sum_q <= sum_q + (DW+AW)'(bus.adc_data);
        if (bus.adc_data > max_q) max_q <= bus.adc_data;
        if (bus.adc_data < min_q) min_q <= bus.adc_data;
      end
      // Pointer saturates on the last slot so the FSM keeps seeing fac.
      if (inc && (wr_addr_q != LAST)) wr_addr_q <= wr_addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wr_addr_q] <= bus.adc_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else     rd_q <= mem[bus.rd_addr];
  end

  assign bus.eoc     = eoc_q;
  assign bus.fac     = (wr_addr_q == LAST);
  assign bus.wr_addr = wr_addr_q;
  assign bus.max_val = max_q;
  assign bus.min_val = min_q;
  assign bus.sum     = sum_q;
  assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_adq_datapath.sv
// Directed plus randomised check of adq_datapath against a behavioural acquisition model.
module tb_adq_datapath;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adq_datapath_if #(.DW(12), .AW(4)) b16 ();
  adq_datapath_if #(.DW(12), .AW(4)) b4 ();

  adq_datapath #(.DW(12), .AW(4), .NSAMP(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  adq_datapath #(.DW(12), .AW(4), .NSAMP(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));

  int total = 0;
  int bad   = 0;

  // Reference model for the NSAMP=16 instance
  int m_mem [16];
  bit m_valid [16];
  int m_wr, m_sum, m_max, m_min;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_wr = 0; m_sum = 0; m_max = 0; m_min = 12'hFFF;
  endtask

  // One cycle on the NSAMP=16 instance, checked against the model.
  task automatic apply16(input logic [6:0] c, input logic [11:0] d, input logic [3:0] ra);
    int exp_rd;
    bit rd_known;
    b16.ctrl = c; b16.adc_data = d; b16.rd_addr = ra;
    #1;
    check("soc16",  b16.adc_soc, c[3]);
    check("busy16", b16.busy,    c[0]);
    check("done16", b16.done,    c[6]);
    exp_rd   = m_mem[ra];
    rd_known = m_valid[ra];
    if (c[1]) model_clear();
    else begin
      if (c[5]) begin m_mem[m_wr] = d; m_valid[m_wr] = 1'b1; end
      if (c[4]) begin
        m_sum = (m_sum + int'(d)) % 65536;
        if (d > m_max) m_max = d;
        if (d < m_min) m_min = d;
      end
      if (c[2] && m_wr < 15) m_wr++;
    end
    tick();
    check("wr16",  b16.wr_addr, m_wr);
    check("sum16", b16.sum,     m_sum);
    check("max16", b16.max_val, m_max);
    check("min16", b16.min_val, m_min);
    check("fac16", b16.fac,     m_wr == 15);
    if (rd_known) check("rd16", b16.rd_data, exp_rd);
  endtask

  int samples [4] = '{100, 200, 50, 300};

  initial begin
    int cnt, first;
    bit seen;
    logic [6:0] rc;

    b16.ctrl = '0; b16.adc_eoc_raw = 1'b0; b16.adc_data = '0; b16.rd_addr = '0;
    b4.ctrl  = '0; b4.adc_eoc_raw  = 1'b0; b4.adc_data  = '0; b4.rd_addr  = '0;
    for (int i = 0; i < 16; i++) begin m_mem[i] = 0; m_valid[i] = 1'b0; end
    model_clear();

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    check("rst_wr",  b16.wr_addr, 0);
    check("rst_min", b16.min_val, 12'hFFF);
    check("rst_max", b16.max_val, 0);
    check("rst_sum", b16.sum,     0);
    check("rst_eoc", b16.eoc,     0);
    check("rst_fac", b16.fac,     0);
    check("rst_rd",  b16.rd_data, 0);
    check("rst_fac4", b4.fac,     0);
    tick();
    rst = 1'b0;
    tick();

    // NSAMP=4 FSM-style acquisition
    for (int i = 0; i < 4; i++) begin
      b4.ctrl = 7'h08;
      #1 check("b4_soc", b4.adc_soc, 1);
      tick();
      b4.ctrl = 7'h01; b4.adc_eoc_raw = 1'b1;
      #1 check("b4_busy", b4.busy, 1);
      check("b4_soc_low", b4.adc_soc, 0);
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
        tick();
        if (b4.eoc) seen = 1'b1;
      end
      check("b4_eoc_seen", seen, 1);
      b4.adc_eoc_raw = 1'b0;
      b4.ctrl = 7'h30; b4.adc_data = samples[i][11:0];
      tick();
      b4.ctrl = 7'h04;
      #1 check("b4_wr", b4.wr_addr, i);
      check("b4_fac", b4.fac, i == 3);
      tick();
      check("b4_fac_after", b4.fac, b4.wr_addr == 2'd3 ? 1'b1 : 1'b0);
    end
    check("b4_wr_sat", b4.wr_addr, 3);
    b4.ctrl = 7'h40;
    #1 check("b4_done", b4.done, 1);
    tick();
    check("b4_max", b4.max_val, 300);
    check("b4_min", b4.min_val, 50);
    check("b4_sum", b4.sum,     650);
    b4.ctrl = 7'h00;
    for (int i = 0; i < 4; i++) begin
      b4.rd_addr = 4'(i);
      tick();
      check("b4_rd", b4.rd_data, samples[i]);
    end
    check("b4_done_low", b4.done, 0);

    // EOC synchroniser: one pulse per rise, none on the fall
    for (int r = 0; r < 2; r++) begin
      #3 b16.adc_eoc_raw = 1'b1;
      cnt = 0; first = 0;
      for (int k = 1; k <= 10; k++) begin
        tick();
        if (b16.eoc) begin cnt++; if (first == 0) first = k; end
        if (k == 5) b16.adc_eoc_raw = 1'b0;
      end
      check("eoc_count", cnt, 1);
      check("eoc_lat_ok", (first >= 2 && first <= 3), 1);
    end

    // Two samples then CLR; buffer contents survive
    for (int i = 0; i < 2; i++) begin
      apply16(7'h30, 12'($urandom_range(0, 4095)), 4'd0);
      apply16(7'h04, 12'd0, 4'd0);
    end
    apply16(7'h02, 12'd0, 4'd0);
    check("clr_min", b16.min_val, 12'hFFF);
    apply16(7'h00, 12'd0, 4'd0);
    apply16(7'h00, 12'd0, 4'd1);

    // CLR beats INC, then pointer saturation
    for (int i = 0; i < 5; i++) apply16(7'h04, 12'd0, 4'd0);
    check("wr_at5", b16.wr_addr, 5);
    apply16(7'h06, 12'd0, 4'd0);
    check("clr_inc", b16.wr_addr, 0);
    for (int i = 0; i < 20; i++) apply16(7'h04, 12'd0, 4'd0);
    check("sat15", b16.wr_addr, 15);

    // WRITE alone, then LATCH alone
    apply16(7'h02, 12'd0, 4'd0);
    apply16(7'h20, 12'($urandom_range(0, 4095)), 4'd0);
    apply16(7'h00, 12'd0, 4'd0);
    apply16(7'h10, 12'($urandom_range(0, 4095)), 4'd0);
    apply16(7'h00, 12'd0, 4'd0);

    // Sum of 16 full-scale samples fits exactly
    apply16(7'h02, 12'd0, 4'd0);
    for (int i = 0; i < 16; i++) apply16(7'h10, 12'hFFF, 4'd0);
    check("sum_full", b16.sum, 16'hFFF0);

    // Random control words, data and read addresses
    for (int i = 0; i < 80; i++) begin
      rc = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) rc[1] = 1'b0;
      apply16(rc, 12'($urandom_range(0, 4095)), 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adq_datapath.md
Name: adq_datapath

Overview:
- Datapath and ADC-interface stage directly downstream of the acquisition-control FSM.
- Decodes the FSM's 7-bit control word. Drives the ADC start-of-conversion.
- Synchronises the ADC end-of-conversion back to the FSM.
- Stores each sample into an internal buffer, tracks running statistics, and returns the `fac` (final acquisition count) flag the FSM polls.

Parameters:
- DW, 12, ADC sample width in bits.
- AW, 4, buffer address width.
- NSAMP, 16, samples per acquisition; legal range 1..2^AW.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ctrl  in  7  FSM control word (FSM present state).
- adc_eoc_raw  in  1  ADC end-of-conversion, asynchronous to clk.
- adc_data  in  DW  ADC result; stable while adc_eoc_raw is high.
- adc_soc  out  1  ADC start-of-conversion.
- eoc  out  1  synchronised end-of-conversion pulse to FSM.
- fac  out  1  last sample slot reached, to FSM.
- busy  out  1  conversion in progress.
- done  out  1  acquisition complete.
- wr_addr  out  AW  current buffer write pointer.
- rd_addr  in  AW  host read address.
- rd_data  out  DW  host read data.
- max_val  out  DW  largest sample since last clear.
- min_val  out  DW  smallest sample since last clear.
- sum  out  DW+AW  sum of samples since last clear.

Behaviour:

Reset:
- Reset is clk, rst only: asynchronous, active-high on rst; clock clk.
- On reset: wr_addr=0, max_val=0, min_val=all ones, sum=0, rd_data=0, synchroniser flops=0.
- All outputs settle to their decoded values accordingly.
- Buffer contents are not reset.

Control bit decode (each bit acts independently, evaluated every clk):
- ctrl[1] CLR: next edge sets wr_addr=0, sum=0, max_val=0, min_val=all ones. Has priority over ctrl[2], [4] and [5] in the same cycle.
- ctrl[3] SOC: adc_soc = ctrl[3], combinational. Exactly one cycle high per pass through the FSM's start-conversion state.
- ctrl[0] WAIT: busy = ctrl[0], combinational.
- ctrl[4] LATCH: next edge updates statistics from adc_data.
  - sum += adc_data, zero-extended, wrapping modulo 2^(DW+AW).
  - max_val = adc_data if adc_data > max_val (unsigned).
  - min_val = adc_data if adc_data < min_val (unsigned).
- ctrl[5] WRITE: next edge writes mem[wr_addr] = adc_data.
- ctrl[2] INC: next edge increments wr_addr, unless wr_addr == NSAMP-1, in which case wr_addr holds (saturates, no wrap).
- ctrl[6] DONE: done = ctrl[6], combinational.

fac:
- fac = (wr_addr == NSAMP-1), combinational from the registered pointer.
- Therefore valid in the same cycle the FSM is in its increment state and samples fac.

eoc path:
- adc_eoc_raw passes through a 2-flop synchroniser, then a rising-edge detector.
- eoc is a one-clk pulse, 2–3 clk after the raw rise. No further pulse until raw falls and rises again.
- eoc pulses are generated regardless of ctrl.

Read port:
- rd_data = mem[rd_addr], registered; 1-cycle latency.
- Read of the slot being written in the same cycle returns the old data.
- rd_addr >= NSAMP returns undefined content (no error flagging).

Other rules:
- Unknown or multi-hot ctrl values: each bit still acts per its rule.
- ctrl=0 leaves all state unchanged.
- Reset mid-operation: asynchronous clear of the registers listed under Reset. A write in the same cycle as rst assertion may or may not complete.
- Expected FSM cycle per sample: 0x08 (SOC) → 0x01 (wait for eoc) → 0x30 (LATCH + WRITE) → 0x04 (INC, FSM checks fac) → 0x08 or 0x40.

Test Plan:
- rst pulse mid-cycle, no clk edge → immediately wr_addr=0, min_val=0xFFF, max_val=0, sum=0, eoc=0; fac=0 for NSAMP=16.
- NSAMP=4, FSM-style ctrl sequence, adc_data samples 100, 200, 50, 300:
  - buffer = {100, 200, 50, 300}; max_val=300, min_val=50, sum=650.
  - fac high only while wr_addr=3; done high on ctrl=0x40.
  - rd_addr=2 → rd_data=50 one cycle later.
- adc_eoc_raw rising between edges, held 5 cycles → exactly one eoc pulse, 2–3 clk later; none on fall. Re-rise → second pulse.
- After 2 samples, ctrl=0x02 → wr_addr=0, sum=0, max_val=0, min_val=0xFFF; buffer slots 0–1 retain old data.
- ctrl=0x06 (CLR and INC) at wr_addr=5 → wr_addr=0. Then ctrl=0x04 repeated 20 times with NSAMP=16 → wr_addr saturates at 15, fac stays high.
- ctrl=0x20 and ctrl=0x10 issued separately → only a write, then only a statistics update, respectively. Data 0xFFF with AW=4, accumulated 16 times → sum=0xFFF0, no overflow.
